// File: rtl/mem_bus_demux.sv
// mem_bus_demux: routes single outstanding core requests to a RAM target (m0)
// or an MMIO target (m1) by address decode, with misalignment rejection and a
// per-transaction timeout that turns a stalled target into an error response.
module mem_bus_demux #(
  parameter logic [31:0] MMIO_BASE = 32'h4000_0000,
  parameter logic [31:0] MMIO_MASK = 32'hF000_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // core side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  // target 0 (RAM)
  output logic        m0_req_valid,
  input  logic        m0_req_ready,
  output logic [31:0] m0_addr,
  output logic [31:0] m0_wdata,
  output logic        m0_we,
  output logic [3:0]  m0_be,
  input  logic        m0_rsp_valid,
  input  logic [31:0] m0_rsp_rdata,
  // target 1 (MMIO)
  output logic        m1_req_valid,
  input  logic        m1_req_ready,
  output logic [31:0] m1_addr,
  output logic [31:0] m1_wdata,
  output logic        m1_we,
  output logic [3:0]  m1_be,
  input  logic        m1_rsp_valid,
  input  logic [31:0] m1_rsp_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // The counter starts at 0 on the first ISSUE cycle and the timeout fires on
  // the cycle whose increment would reach TIMEOUT-1, so a target that never
  // answers sees exactly TIMEOUT-1 cycles of ISSUE/WAIT. ">=" keeps the
  // timeout armed after a handshake that won against it on the boundary cycle.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 2);

  state_e      state_q, state_d;
  logic        sel_q, sel_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        tgt_ready;
  logic        tgt_rsp;
  logic [31:0] tgt_rdata;
  logic        to_hit;
  logic        addr_is_mmio;

  // Only the selected target's handshake and response are ever looked at.
  assign tgt_ready    = sel_q ? m1_req_ready : m0_req_ready;
  assign tgt_rsp      = sel_q ? m1_rsp_valid : m0_rsp_valid;
  assign tgt_rdata    = sel_q ? m1_rsp_rdata : m0_rsp_rdata;
  assign to_hit       = (cnt_q >= TO_LAST);
  assign addr_is_mmio = ((req_addr & MMIO_MASK) == (MMIO_BASE & MMIO_MASK));

  // State, latched request fields and response registers; all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      cnt_q   <= 16'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept, issue, wait for response or timeout, respond.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          be_d    = req_be;
          sel_d   = addr_is_mmio;
          cnt_d   = 16'd0;
          if (req_addr[1:0] != 2'b00) begin
            // Misaligned: answered locally, never reaches a target.
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 16'd1;
        if (tgt_ready) begin
          state_d = S_WAIT;
        end else if (to_hit) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (tgt_rsp) begin
          state_d = S_RESP;
          err_d   = 1'b0;
          rdata_d = tgt_rdata;
        end else if (to_hit) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // The unselected target sees an all-zero request bus.
  assign m0_req_valid = (state_q == S_ISSUE) && !sel_q;
  assign m0_addr      = sel_q ? 32'd0 : addr_q;
  assign m0_wdata     = sel_q ? 32'd0 : wdata_q;
  assign m0_we        = sel_q ? 1'b0  : we_q;
  assign m0_be        = sel_q ? 4'd0  : be_q;

  assign m1_req_valid = (state_q == S_ISSUE) && sel_q;
  assign m1_addr      = sel_q ? addr_q  : 32'd0;
  assign m1_wdata     = sel_q ? wdata_q : 32'd0;
  assign m1_we        = sel_q ? we_q    : 1'b0;
  assign m1_be        = sel_q ? be_q    : 4'd0;

endmodule

// File: tb/tb_mem_bus_demux.sv
// Directed bench for mem_bus_demux (instantiated with TIMEOUT=4).
module tb_mem_bus_demux;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        m0_req_valid, m1_req_valid;
  logic        m0_req_ready, m1_req_ready;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_we, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic        m0_rsp_valid, m1_rsp_valid;
  logic [31:0] m0_rsp_rdata, m1_rsp_rdata;

  int checks;
  int failures;

  mem_bus_demux #(
    .MMIO_BASE(32'h4000_0000),
    .MMIO_MASK(32'hF000_0000),
    .TIMEOUT  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_we      (req_we),
    .req_be      (req_be),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .m0_req_valid(m0_req_valid),
    .m0_req_ready(m0_req_ready),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_we       (m0_we),
    .m0_be       (m0_be),
    .m0_rsp_valid(m0_rsp_valid),
    .m0_rsp_rdata(m0_rsp_rdata),
    .m1_req_valid(m1_req_valid),
    .m1_req_ready(m1_req_ready),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_we       (m1_we),
    .m1_be       (m1_be),
    .m1_rsp_valid(m1_rsp_valid),
    .m1_rsp_rdata(m1_rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (rsp_rdata !== 32'd0) begin failures++; $display("FAIL rst_rsp_rdata got=%h exp=0", rsp_rdata); end
    checks++; if ({m0_req_valid, m1_req_valid} !== 2'b00) begin failures++; $display("FAIL rst_req_valid got=%b exp=00", {m0_req_valid, m1_req_valid}); end
    checks++; if (m0_addr !== 32'd0) begin failures++; $display("FAIL rst_m0_addr got=%h exp=0", m0_addr); end
    rst_n = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_read_ram();
    // cycle N: request presented and accepted
    req_valid = 1'b1; req_addr = 32'h0000_1000; req_we = 1'b0; req_be = 4'hF; req_wdata = 32'h0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rd_ready_n got=%b exp=1", req_ready); end
    step(); // N+1: ISSUE
    req_valid = 1'b0;
    checks++; if (m0_req_valid !== 1'b1) begin failures++; $display("FAIL rd_m0_valid got=%b exp=1", m0_req_valid); end
    checks++; if (m1_req_valid !== 1'b0) begin failures++; $display("FAIL rd_m1_valid got=%b exp=0", m1_req_valid); end
    checks++; if (m0_addr !== 32'h0000_1000) begin failures++; $display("FAIL rd_m0_addr got=%h exp=00001000", m0_addr); end
    checks++; if (m1_addr !== 32'd0) begin failures++; $display("FAIL rd_m1_addr got=%h exp=0", m1_addr); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rd_ready_busy got=%b exp=0", req_ready); end
    m0_req_ready = 1'b1;
    step(); // N+2: WAIT
    m0_req_ready = 1'b0;
    checks++; if (m0_req_valid !== 1'b0) begin failures++; $display("FAIL rd_m0_valid_wait got=%b exp=0", m0_req_valid); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_rsp_early got=%b exp=0", rsp_valid); end
    m0_rsp_valid = 1'b1; m0_rsp_rdata = 32'hDEAD_BEEF;
    step(); // N+3: RESP
    m0_rsp_valid = 1'b0; m0_rsp_rdata = 32'h0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rd_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_rdata got=%h exp=deadbeef", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", rsp_err); end
    step(); // N+4: back in IDLE, data held
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_rsp_one_cycle got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_rdata_hold got=%h exp=deadbeef", rsp_rdata); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rd_ready_after got=%b exp=1", req_ready); end
  endtask

  task automatic test_timeout();
    req_valid = 1'b1; req_addr = 32'h4000_0000; req_we = 1'b0; req_be = 4'hF;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++; if (m1_req_valid !== 1'b1) begin failures++; $display("FAIL to_m1_valid cyc=%0d got=%b exp=1", k, m1_req_valid); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL to_rsp_early cyc=%0d got=%b exp=0", k, rsp_valid); end
      step();
    end
    checks++; if (m1_req_valid !== 1'b0) begin failures++; $display("FAIL to_m1_dropped got=%b exp=0", m1_req_valid); end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL to_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", rsp_err); end
    checks++; if (rsp_rdata !== 32'd0) begin failures++; $display("FAIL to_rdata got=%h exp=0", rsp_rdata); end
    step();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL to_ready_after got=%b exp=1", req_ready); end
  endtask

  task automatic test_write_mmio();
    req_valid = 1'b1; req_addr = 32'h4000_0010; req_wdata = 32'h1234_5678; req_we = 1'b1; req_be = 4'b1111;
    step();
    req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_we = 1'b0; req_be = 4'h0;
    for (int k = 1; k <= 3; k++) begin
      checks++; if (m1_req_valid !== 1'b1) begin failures++; $display("FAIL wr_m1_valid cyc=%0d got=%b exp=1", k, m1_req_valid); end
      checks++; if ({m1_addr, m1_wdata, m1_be, m1_we} !== {32'h4000_0010, 32'h1234_5678, 4'hF, 1'b1}) begin
        failures++; $display("FAIL wr_m1_fields cyc=%0d got=%h/%h/%h/%b exp=40000010/12345678/f/1", k, m1_addr, m1_wdata, m1_be, m1_we);
      end
      checks++; if ({m0_req_valid, m0_addr, m0_wdata} !== 65'd0) begin failures++; $display("FAIL wr_m0_idle cyc=%0d got=%b/%h/%h exp=0", k, m0_req_valid, m0_addr, m0_wdata); end
      if (k == 3) m1_req_ready = 1'b1;
      step();
    end
    m1_req_ready = 1'b0;
    checks++; if (m1_req_valid !== 1'b0) begin failures++; $display("FAIL wr_m1_after_hs got=%b exp=0", m1_req_valid); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_rsp_early got=%b exp=0", rsp_valid); end
    m1_rsp_valid = 1'b1; m1_rsp_rdata = 32'h0BAD_F00D;
    step();
    m1_rsp_valid = 1'b0; m1_rsp_rdata = 32'h0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL wr_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", rsp_err); end
    step();
  endtask

  task automatic test_misaligned();
    req_valid = 1'b1; req_addr = 32'h0000_0002; req_we = 1'b0; req_be = 4'hF;
    step(); // N+1
    req_valid = 1'b0; req_addr = 32'h0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL mis_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_err !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", rsp_err); end
    checks++; if (rsp_rdata !== 32'd0) begin failures++; $display("FAIL mis_rdata got=%h exp=0", rsp_rdata); end
    checks++; if ({m0_req_valid, m1_req_valid} !== 2'b00) begin failures++; $display("FAIL mis_req_valid got=%b exp=00", {m0_req_valid, m1_req_valid}); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mis_rsp_one_cycle got=%b exp=0", rsp_valid); end
    checks++; if (rsp_err !== 1'b1) begin failures++; $display("FAIL mis_err_hold got=%b exp=1", rsp_err); end
    checks++; if ({m0_req_valid, m1_req_valid} !== 2'b00) begin failures++; $display("FAIL mis_req_valid2 got=%b exp=00", {m0_req_valid, m1_req_valid}); end
  endtask

  task automatic test_stray_rsp();
    // stray response while IDLE
    m0_rsp_valid = 1'b1; m0_rsp_rdata = 32'h1111_1111;
    step();
    m0_rsp_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL stray_idle_rsp got=%b exp=0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL stray_idle_ready got=%b exp=1", req_ready); end
    // m1 read with m0 noise during ISSUE and WAIT
    req_valid = 1'b1; req_addr = 32'h4000_0100; req_we = 1'b0; req_be = 4'hF;
    step(); // ISSUE
    req_valid = 1'b0;
    checks++; if (m1_req_valid !== 1'b1) begin failures++; $display("FAIL stray_m1_valid got=%b exp=1", m1_req_valid); end
    m1_req_ready = 1'b1; m0_rsp_valid = 1'b1; m0_rsp_rdata = 32'h2222_2222;
    step(); // WAIT, cnt=1
    m1_req_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL stray_wait1 got=%b exp=0", rsp_valid); end
    step(); // WAIT, cnt=2
    m0_rsp_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL stray_wait2 got=%b exp=0", rsp_valid); end
    m1_rsp_valid = 1'b1; m1_rsp_rdata = 32'hCAFE_F00D;
    step();
    m1_rsp_valid = 1'b0; m1_rsp_rdata = 32'h0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL stray_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL stray_rdata got=%h exp=cafef00d", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL stray_err got=%b exp=0", rsp_err); end
    step();
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_addr = 32'h0000_2000; req_we = 1'b0; req_be = 4'hF;
    step(); // ISSUE
    req_valid = 1'b0;
    m0_req_ready = 1'b1;
    step(); // WAIT
    m0_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin failures++; $display("FAIL midrst_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (m0_addr !== 32'd0) begin failures++; $display("FAIL midrst_m0_addr got=%h exp=0", m0_addr); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", req_ready); end
    step();
    rst_n = 1'b1;
    step();
    m0_rsp_valid = 1'b1; m0_rsp_rdata = 32'h3333_3333;
    step();
    m0_rsp_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_late1 got=%b exp=0", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_late2 got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin failures++; $display("FAIL midrst_late_rdata got=%h exp=0", rsp_rdata); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_we = 1'b0; req_be = 4'h0;
    m0_req_ready = 1'b0; m1_req_ready = 1'b0;
    m0_rsp_valid = 1'b0; m1_rsp_valid = 1'b0;
    m0_rsp_rdata = 32'h0; m1_rsp_rdata = 32'h0;
    test_reset();
    test_read_ram();
    test_timeout();
    test_write_mmio();
    test_misaligned();
    test_stray_rsp();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
